// File: rtl/ext_pkg.sv
// Shared definitions for the extend arbiter: mode encodings, FSM state type,
// datapath widths and the extend helper used by the mode datapath.
// Optional feature EXT_ARB_STATS_EN (per-requester grant counters) lives in ext_arbiter.
package ext_pkg;

   localparam int DATA_W = 16;
   localparam int RES_W  = 32;

   // Extend mode encodings carried on reqN_mode_i
   typedef enum logic [1:0] {
      EXT_SIGN  = 2'b00,
      EXT_ZERO  = 2'b01,
      EXT_UPPER = 2'b10,
      EXT_BR    = 2'b11
   } ext_mode_e;

   // Result slot occupancy
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } ext_state_e;

   // Build the 32-bit result for one 16-bit immediate and its mode
   function automatic logic [RES_W-1:0] ext_apply(input logic [DATA_W-1:0] d,
                                                  input ext_mode_e         m);
      logic [RES_W-1:0] r;
      r = '0;
      case (m)
         EXT_SIGN:  r = {{16{d[15]}}, d};
         EXT_ZERO:  r = {16'h0000, d};
         EXT_UPPER: r = {d, 16'h0000};
         EXT_BR:    r = {{14{d[15]}}, d, 2'b00};
         default:   r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ext_unit.sv
// Purpose: combinational immediate extender (sign, zero, upper, branch offset).
// Latency: 0 cycles, pure combinational.
// Backpressure: none; the arbiter feeds it the granted requester only.
module ext_unit
   import ext_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        mode_i,
   output logic [RES_W-1:0]  res_o
);

   logic [RES_W-1:0] w_res;

   // Apply the selected extension to the shared operand
   always_comb begin
      w_res = ext_apply(data_i, ext_mode_e'(mode_i));
   end

   assign res_o = w_res;

endmodule

// File: rtl/ext_arbiter.sv
// Purpose: round-robin arbiter of two immediate requesters into one extend unit and a one-entry result register.
// Latency: 1 cycle from accepted request to res_valid_o; readies are combinational.
// Backpressure: readies drop to 0 while the result slot is held and not drained. Optional EXT_ARB_STATS_EN adds saturating grant counters.
module ext_arbiter
   import ext_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_valid_i,
   input  logic [DATA_W-1:0] req0_data_i,
   input  logic [1:0]        req0_mode_i,
   output logic              req0_ready_o,
   input  logic              req1_valid_i,
   input  logic [DATA_W-1:0] req1_data_i,
   input  logic [1:0]        req1_mode_i,
   output logic              req1_ready_o,
   output logic              res_valid_o,
   output logic [RES_W-1:0]  res_data_o,
   output logic              res_id_o,
`ifdef EXT_ARB_STATS_EN
   output logic [CNT_W-1:0]  grant0_cnt_o,
   output logic [CNT_W-1:0]  grant1_cnt_o,
`endif
   input  logic              res_ready_i
);

   // A zero-width counter makes no sense in either build
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("ext_arbiter: CNT_W must be at least 1");
   end

   ext_state_e       r_state;
   logic             r_ptr;
   logic [RES_W-1:0] r_data;
   logic             r_id;

   logic              w_xfer;
   logic              w_free;
   logic              w_both;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_grant;
   logic [DATA_W-1:0] w_sel_data;
   logic [1:0]        w_sel_mode;
   logic [RES_W-1:0]  w_ext;

   // Slot frees up when empty or drained on this edge; held low while in reset
   assign w_xfer = (r_state == ST_FULL) & res_ready_i;
   assign w_free = rst_i & ((r_state == ST_EMPTY) | w_xfer);
   assign w_both = req0_valid_i & req1_valid_i;

   // Pick one requester: pointer breaks ties, a lone requester always wins
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (w_both) begin
         if (r_ptr) w_gnt1 = 1'b1;
         else       w_gnt0 = 1'b1;
      end else if (req0_valid_i) begin
         w_gnt0 = 1'b1;
      end else if (req1_valid_i) begin
         w_gnt1 = 1'b1;
      end
   end

   assign req0_ready_o = w_free & w_gnt0;
   assign req1_ready_o = w_free & w_gnt1;
   assign w_grant      = req0_ready_o | req1_ready_o;

   // Route the winning operand into the single shared extender
   always_comb begin
      w_sel_data = req0_data_i;
      w_sel_mode = req0_mode_i;
      if (w_gnt1) begin
         w_sel_data = req1_data_i;
         w_sel_mode = req1_mode_i;
      end
   end

   ext_unit u_ext_unit (
      .data_i (w_sel_data),
      .mode_i (w_sel_mode),
      .res_o  (w_ext)
   );

   // Result slot FSM, result register and round-robin pointer
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= ST_EMPTY;
         r_data  <= '0;
         r_id    <= 1'b0;
         r_ptr   <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_grant) begin
                  r_state <= ST_FULL;
                  r_data  <= w_ext;
                  r_id    <= w_gnt1;
               end
            end
            ST_FULL: begin
               if (w_xfer) begin
                  if (w_grant) begin
                     r_data <= w_ext;
                     r_id   <= w_gnt1;
                  end else begin
                     r_state <= ST_EMPTY;
                  end
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
         // Pointer only moves on a contested grant, to the loser
         if (w_grant && w_both) begin
            r_ptr <= w_gnt0;
         end
      end
   end

   assign res_valid_o = (r_state == ST_FULL);
   assign res_data_o  = r_data;
   assign res_id_o    = r_id;

`ifdef EXT_ARB_STATS_EN
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   // Saturating accepted-request counters, one per requester
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (req0_ready_o && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + 1'b1;
         if (req1_ready_o && (r_cnt1 != {CNT_W{1'b1}})) r_cnt1 <= r_cnt1 + 1'b1;
      end
   end

   assign grant0_cnt_o = r_cnt0;
   assign grant1_cnt_o = r_cnt1;
`endif

endmodule
